// File: rtl/eth_rx_pkg.sv
// Shared constants, state encoding and CRC helper for the RMII receive path.
package eth_rx_pkg;

    localparam int pMII_WIDTH = 2;

    localparam logic [2:0] pRX_IDLE     = 3'd0;
    localparam logic [2:0] pRX_PREAMBLE = 3'd1;
    localparam logic [2:0] pRX_HEADER   = 3'd2;
    localparam logic [2:0] pRX_DATA     = 3'd3;
    localparam logic [2:0] pRX_DONE     = 3'd4;
    localparam logic [2:0] pRX_DROP     = 3'd5;

    typedef enum logic [2:0] {
        RX_IDLE     = pRX_IDLE,
        RX_PREAMBLE = pRX_PREAMBLE,
        RX_HEADER   = pRX_HEADER,
        RX_DATA     = pRX_DATA,
        RX_DONE     = pRX_DONE,
        RX_DROP     = pRX_DROP
    } rx_state_t;

    localparam int pPREAMBLE_MIN = 8;
    localparam int pHDR_BYTES    = 14;
    localparam int pMIN_FRAME    = 64;

    // Header byte boundaries: dest occupies 0..5, src 6..11, Len/Type 12..13.
    localparam int pDEST_END = 6;
    localparam int pSRC_END  = 12;

    localparam logic [31:0] pCRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] pCRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] pCRC_RESIDUE   = 32'hDEBB_20E3;

    localparam logic [1:0] pDIBIT_PRE = 2'b01;
    localparam logic [1:0] pDIBIT_SFD = 2'b11;

    // One byte of the reflected CRC-32, least significant bit first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ pCRC_POLY_REFL;
            else      c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_crc_chk.sv
// Running CRC-32 over received bytes; flags the fixed residue left by a good FCS.
module eth_rx_crc_chk
    import eth_rx_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Init,
    input  logic       Byte_Rdy,
    input  logic [7:0] Byte,
    output logic       Residue_Ok
);

    logic [31:0] crc;

    // Restart on reset or SFD, otherwise fold in one byte per strobe.
    always_ff @(posedge Clk) begin
        if (Rst || Init) begin
            crc <= pCRC_INIT;
        end else if (Byte_Rdy) begin
            crc <= crc32_byte(crc, Byte);
        end
    end

    assign Residue_Ok = (crc == pCRC_RESIDUE);

endmodule

// File: rtl/eth_rx.sv
// RMII Ethernet receiver: preamble/SFD hunt, header capture, payload delay line, FCS check.
module eth_rx
    import eth_rx_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [pMII_WIDTH-1:0] Rxd,
    input  logic                  Crs_Dv,
    output logic [7:0]            Eth_Byte,
    output logic                  Eth_Byte_Valid,
    output logic [47:0]           Eth_Dest_Addr,
    output logic [47:0]           Eth_Src_Addr,
    output logic [15:0]           Eth_Len_Type,
    output logic                  Eth_Pkt_Done,
    output logic                  Eth_Crc_Ok,
    output logic                  Eth_Pkt_Err
);

    rx_state_t   state;
    rx_state_t   next_state;

    logic [4:0]  pre_cnt;
    logic [1:0]  dibit_cnt;
    logic [10:0] byte_cnt;
    logic [7:0]  shifter;
    logic [31:0] dline;
    logic [2:0]  fill_cnt;
    logic        after_rst;

    logic [7:0]  assembled;
    logic        in_frame;
    logic        byte_done;
    logic        sfd_seen;
    logic        residue_ok;

    assign assembled = {Rxd, shifter[7:2]};
    assign in_frame  = ((state == RX_HEADER) || (state == RX_DATA)) && Crs_Dv;
    assign byte_done = in_frame && (dibit_cnt == 2'd3);
    assign sfd_seen  = (state == RX_PREAMBLE) && Crs_Dv && (Rxd == pDIBIT_SFD) &&
                       (pre_cnt >= 5'(pPREAMBLE_MIN));

    eth_rx_crc_chk u_crc (
        .Clk        (Clk),
        .Rst        (Rst),
        .Init       (sfd_seen),
        .Byte_Rdy   (byte_done),
        .Byte       (assembled),
        .Residue_Ok (residue_ok)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= RX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; a carrier seen right after reset is the tail of an aborted frame.
    always_comb begin
        next_state = state;
        unique case (state)
            RX_IDLE: begin
                if (Crs_Dv) begin
                    if (after_rst)                next_state = RX_DROP;
                    else if (Rxd == pDIBIT_PRE)   next_state = RX_PREAMBLE;
                end
            end
            RX_PREAMBLE: begin
                if (!Crs_Dv)                      next_state = RX_DROP;
                else if (Rxd == pDIBIT_PRE)       next_state = RX_PREAMBLE;
                else if (sfd_seen)                next_state = RX_HEADER;
                else                              next_state = RX_DROP;
            end
            RX_HEADER: begin
                if (!Crs_Dv)                      next_state = RX_DONE;
                else if (byte_done && (byte_cnt == 11'(pHDR_BYTES - 1)))
                                                  next_state = RX_DATA;
            end
            RX_DATA: begin
                if (!Crs_Dv)                      next_state = RX_DONE;
            end
            RX_DONE: begin
                next_state = RX_IDLE;
            end
            RX_DROP: begin
                if (!Crs_Dv)                      next_state = RX_IDLE;
            end
            default: begin
                next_state = RX_IDLE;
            end
        endcase
    end

    // Remember that the previous cycle was in reset so a live carrier can be discarded.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            after_rst <= 1'b1;
        end else begin
            after_rst <= 1'b0;
        end
    end

    // Count preamble dibits, saturating so long preambles cannot wrap below the minimum.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pre_cnt <= '0;
        end else if (state == RX_PREAMBLE) begin
            if (Crs_Dv && (Rxd == pDIBIT_PRE) && (pre_cnt != 5'd31)) begin
                pre_cnt <= pre_cnt + 5'd1;
            end
        end else begin
            pre_cnt <= '0;
        end
    end

    // Assemble dibits into bytes and count bytes from the first destination byte.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            shifter   <= '0;
            dibit_cnt <= '0;
            byte_cnt  <= '0;
        end else if (sfd_seen) begin
            shifter   <= '0;
            dibit_cnt <= '0;
            byte_cnt  <= '0;
        end else if (in_frame) begin
            shifter   <= assembled;
            dibit_cnt <= dibit_cnt + 2'd1;
            if (byte_done && (byte_cnt != 11'd2047)) begin
                byte_cnt <= byte_cnt + 11'd1;
            end
        end
    end

    // Shift header bytes into the address and Len/Type registers, first byte ending up on top.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Eth_Dest_Addr <= '0;
            Eth_Src_Addr  <= '0;
            Eth_Len_Type  <= '0;
        end else if (byte_done && (state == RX_HEADER)) begin
            if (byte_cnt < 11'(pDEST_END)) begin
                Eth_Dest_Addr <= {Eth_Dest_Addr[39:0], assembled};
            end else if (byte_cnt < 11'(pSRC_END)) begin
                Eth_Src_Addr <= {Eth_Src_Addr[39:0], assembled};
            end else begin
                Eth_Len_Type <= {Eth_Len_Type[7:0], assembled};
            end
        end
    end

    // Four-byte delay line holds back the FCS; a byte only leaves once four newer ones exist.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            dline          <= '0;
            fill_cnt       <= '0;
            Eth_Byte       <= '0;
            Eth_Byte_Valid <= 1'b0;
        end else begin
            Eth_Byte_Valid <= 1'b0;
            if (sfd_seen) begin
                dline    <= '0;
                fill_cnt <= '0;
            end else if (byte_done && (state == RX_DATA)) begin
                dline <= {dline[23:0], assembled};
                if (fill_cnt == 3'd4) begin
                    Eth_Byte       <= dline[31:24];
                    Eth_Byte_Valid <= 1'b1;
                end else begin
                    fill_cnt <= fill_cnt + 3'd1;
                end
            end
        end
    end

    // End-of-frame pulse with CRC verdict and error flag, produced as the FSM enters DONE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Eth_Pkt_Done <= 1'b0;
            Eth_Crc_Ok   <= 1'b0;
            Eth_Pkt_Err  <= 1'b0;
        end else begin
            Eth_Pkt_Done <= 1'b0;
            Eth_Crc_Ok   <= 1'b0;
            Eth_Pkt_Err  <= 1'b0;
            if (((state == RX_HEADER) || (state == RX_DATA)) && !Crs_Dv) begin
                Eth_Pkt_Done <= 1'b1;
                Eth_Crc_Ok   <= residue_ok;
                Eth_Pkt_Err  <= (dibit_cnt != 2'd0) || (state == RX_HEADER) ||
                                (byte_cnt < 11'(pMIN_FRAME));
            end
        end
    end

endmodule

// File: tb/tb_eth_rx.sv
// Scoreboard bench for eth_rx: directed scenarios plus random frames against a frame-level model.
module tb_eth_rx;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  Rxd;
    logic        Crs_Dv;
    logic [7:0]  Eth_Byte;
    logic        Eth_Byte_Valid;
    logic [47:0] Eth_Dest_Addr;
    logic [47:0] Eth_Src_Addr;
    logic [15:0] Eth_Len_Type;
    logic        Eth_Pkt_Done;
    logic        Eth_Crc_Ok;
    logic        Eth_Pkt_Err;

    typedef struct {
        logic        crc_ok;
        logic        err;
        logic        chk_hdr;
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] len_type;
    } done_t;

    logic [7:0] frame[$];
    logic [7:0] exp_bytes[$];
    done_t      exp_done[$];
    done_t      mon_exp;

    int vectors     = 0;
    int miscompares = 0;

    eth_rx dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rxd            (Rxd),
        .Crs_Dv         (Crs_Dv),
        .Eth_Byte       (Eth_Byte),
        .Eth_Byte_Valid (Eth_Byte_Valid),
        .Eth_Dest_Addr  (Eth_Dest_Addr),
        .Eth_Src_Addr   (Eth_Src_Addr),
        .Eth_Len_Type   (Eth_Len_Type),
        .Eth_Pkt_Done   (Eth_Pkt_Done),
        .Eth_Crc_Ok     (Eth_Crc_Ok),
        .Eth_Pkt_Err    (Eth_Pkt_Err)
    );

    // 50 MHz reference clock.
    always #10 Clk = ~Clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Bit-serial CRC-32 over the first count bytes of the frame, as defined by IEEE 802.3.
    function automatic logic [31:0] ref_crc(input int count);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < count; i++) begin
            b = frame[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] dest, input logic [47:0] src,
                               input logic [15:0] len_type, input int plen,
                               input bit seq_payload, input int corrupt_idx);
        logic [31:0] fcs;
        logic [7:0]  b;
        frame.delete();
        for (int i = 5; i >= 0; i--) frame.push_back(dest[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frame.push_back(src[8*i +: 8]);
        frame.push_back(len_type[15:8]);
        frame.push_back(len_type[7:0]);
        for (int i = 0; i < plen; i++) begin
            if (seq_payload) frame.push_back(8'(i));
            else             frame.push_back(8'($urandom_range(0, 255)));
        end
        fcs = ~ref_crc(frame.size());
        for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
        if (corrupt_idx >= 0) begin
            b = frame[14 + corrupt_idx];
            frame[14 + corrupt_idx] = b ^ 8'h01;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Rst    = 1'b0;
            Crs_Dv = 1'b0;
            Rxd    = 2'b00;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input int bad_dibit);
        for (int d = 0; d < 4; d++) begin
            @(negedge Clk);
            Crs_Dv = 1'b1;
            Rxd    = (d == bad_dibit) ? 2'b00 : b[2*d +: 2];
        end
    endtask

    // Push the expected response for the current frame, then drive it on the wire.
    task automatic apply_stimulus(input int extra, input bit bad_pre, input int rst_at);
        int          n;
        done_t       e;
        logic [7:0]  b;
        n = frame.size();
        if (!bad_pre) begin
            if (rst_at >= 0) begin
                for (int i = 14; (i <= rst_at - 5) && (i <= n - 5); i++) exp_bytes.push_back(frame[i]);
            end else begin
                for (int i = 14; i <= n - 5; i++) exp_bytes.push_back(frame[i]);
                e.crc_ok   = (~ref_crc(n - 4)) == {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
                e.err      = (extra != 0) || (n < 64);
                e.chk_hdr  = (n >= 14);
                e.dest     = '0;
                e.src      = '0;
                e.len_type = '0;
                if (e.chk_hdr) begin
                    for (int i = 0; i < 6; i++) begin
                        e.dest = {e.dest[39:0], frame[i]};
                        e.src  = {e.src[39:0], frame[6 + i]};
                    end
                    e.len_type = {frame[12], frame[13]};
                end
                exp_done.push_back(e);
            end
        end
        for (int i = 0; i < 7; i++) drive_byte(8'h55, (bad_pre && i == 3) ? 2 : -1);
        drive_byte(8'hD5, -1);
        for (int i = 0; i < n; i++) begin
            b = frame[i];
            for (int d = 0; d < 4; d++) begin
                @(negedge Clk);
                if (i == rst_at && d == 1) begin
                    check_output("reset_valid", {63'd0, Eth_Byte_Valid}, 64'd0);
                    check_output("reset_dest", {16'd0, Eth_Dest_Addr}, 64'd0);
                end
                Rst    = (i == rst_at) && (d == 0);
                Crs_Dv = 1'b1;
                Rxd    = b[2*d +: 2];
            end
        end
        for (int i = 0; i < extra; i++) begin
            @(negedge Clk);
            Rst    = 1'b0;
            Crs_Dv = 1'b1;
            Rxd    = 2'($urandom_range(0, 3));
        end
        idle_cycles(12);
    endtask

    // Monitor: pop and compare whenever the DUT strobes a byte or ends a frame.
    always @(negedge Clk) begin
        if (Eth_Byte_Valid) begin
            if (exp_bytes.size() == 0) begin
                check_output("spurious_strobe", {63'd0, Eth_Byte_Valid}, 64'd0);
            end else begin
                check_output("payload_byte", {56'd0, Eth_Byte}, {56'd0, exp_bytes.pop_front()});
            end
        end
        if (Eth_Pkt_Done) begin
            if (exp_done.size() == 0) begin
                check_output("spurious_done", {63'd0, Eth_Pkt_Done}, 64'd0);
            end else begin
                mon_exp = exp_done.pop_front();
                check_output("missing_strobes", 64'(exp_bytes.size()), 64'd0);
                check_output("crc_ok", {63'd0, Eth_Crc_Ok}, {63'd0, mon_exp.crc_ok});
                check_output("pkt_err", {63'd0, Eth_Pkt_Err}, {63'd0, mon_exp.err});
                if (mon_exp.chk_hdr) begin
                    check_output("dest_addr", {16'd0, Eth_Dest_Addr}, {16'd0, mon_exp.dest});
                    check_output("src_addr", {16'd0, Eth_Src_Addr}, {16'd0, mon_exp.src});
                    check_output("len_type", {48'd0, Eth_Len_Type}, {48'd0, mon_exp.len_type});
                end
            end
        end else begin
            check_output("flags_without_done", {62'd0, Eth_Crc_Ok, Eth_Pkt_Err}, 64'd0);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst    = 1'b1;
        Crs_Dv = 1'b0;
        Rxd    = 2'b00;
        repeat (5) @(negedge Clk);
        check_output("rst_byte", {56'd0, Eth_Byte}, 64'd0);
        check_output("rst_valid", {63'd0, Eth_Byte_Valid}, 64'd0);
        check_output("rst_dest", {16'd0, Eth_Dest_Addr}, 64'd0);
        check_output("rst_src", {16'd0, Eth_Src_Addr}, 64'd0);
        check_output("rst_len", {48'd0, Eth_Len_Type}, 64'd0);
        check_output("rst_done", {63'd0, Eth_Pkt_Done}, 64'd0);
        check_output("rst_crc", {63'd0, Eth_Crc_Ok}, 64'd0);
        check_output("rst_err", {63'd0, Eth_Pkt_Err}, 64'd0);
        idle_cycles(4);

        $display("[TB] valid frame");
        build_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 46, 1'b1, -1);
        apply_stimulus(0, 1'b0, -1);

        $display("[TB] corrupted FCS");
        build_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 46, 1'b1, 10);
        apply_stimulus(0, 1'b0, -1);

        $display("[TB] runt");
        build_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 20, 1'b1, -1);
        apply_stimulus(0, 1'b0, -1);

        $display("[TB] alignment error");
        build_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 46, 1'b1, -1);
        apply_stimulus(1, 1'b0, -1);

        $display("[TB] bad preamble then valid frame");
        build_frame(48'h0A0B_0C0D_0E0F, 48'h0200_0000_0001, 16'h0800, 46, 1'b1, -1);
        apply_stimulus(0, 1'b1, -1);
        apply_stimulus(0, 1'b0, -1);

        $display("[TB] reset mid-frame then valid frame");
        build_frame(48'h1122_3344_5566, 48'h0200_0000_0001, 16'h0800, 46, 1'b1, -1);
        apply_stimulus(0, 1'b0, 20);
        apply_stimulus(0, 1'b0, -1);

        $display("[TB] truncated header");
        build_frame(48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h86DD, 0, 1'b1, -1);
        while (frame.size() > 10) void'(frame.pop_back());
        apply_stimulus(0, 1'b0, -1);

        $display("[TB] random frames");
        for (int f = 0; f < 20; f++) begin
            int plen;
            int corrupt;
            int extra;
            plen    = $urandom_range(0, 60);
            corrupt = (plen > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, plen - 1) : -1;
            extra   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            build_frame({$urandom, $urandom_range(0, 65535)}, {$urandom, $urandom_range(0, 65535)},
                        16'($urandom_range(0, 65535)), plen, 1'b0, corrupt);
            apply_stimulus(extra, 1'b0, -1);
        end

        for (int c = 0; c < 100 && (exp_bytes.size() != 0 || exp_done.size() != 0); c++) @(negedge Clk);
        check_output("bytes_drained", 64'(exp_bytes.size()), 64'd0);
        check_output("done_drained", 64'(exp_done.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
